fft_twiddle_seq: RTL and testbench

//  Sequences twiddle-coefficient ROM reads for the radix-4 DIF FFT core.
//  On iSTART it walks every stage and butterfly and drives oADDR_COEF (shared by the W^k/W^2k/W^3k ROMs).
//  It emits oVALID aligned with ROM q, plus stage, butterfly and last tags; the butterfly datapath consumes these under iREADY.

---
 rtl/fft_twiddle_seq.sv | 172 +++++++++++++++++
 tb/tb_fft_twiddle_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_twiddle_seq.sv
// Radix-4 DIF twiddle ROM address sequencer; first beat 2 cycles after iSTART, then 1 beat/cycle.
// oVALID&!iREADY freezes address, beat and tags; optional oROM_EN clock-enable under FFT_ROM_GATE_EN.
module fft_twiddle_seq #(
   parameter int N_LOG4 = 5,
   parameter int ADDR_W = 9
) (
   input  logic                  iCLK,
   input  logic                  iRESET,
   input  logic                  iSTART,
   input  logic                  iABORT,
   input  logic                  iREADY,
   output logic [ADDR_W-1:0]     oADDR_COEF,
   output logic                  oVALID,
   output logic [2:0]            oSTAGE,
   output logic [2*N_LOG4-3:0]   oBUT_IDX,
   output logic                  oLAST_BUT,
   output logic                  oSTAGE_DONE,
   output logic                  oRDY
`ifdef FFT_ROM_GATE_EN
   ,
   output logic                  oROM_EN
`endif
);

   localparam int              BW     = 2*N_LOG4-2;
   localparam logic [2:0]      LAST_S = 3'(N_LOG4-1);
   localparam logic [BW-1:0]   LAST_B = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_s_q, cnt_s_d;
   logic [BW-1:0]     cnt_b_q, cnt_b_d;

   // Issue rank: address in flight to the ROM and its tags.
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              iss_q, iss_d;
   logic [2:0]        iss_s_q, iss_s_d;
   logic [BW-1:0]     iss_b_q, iss_b_d;
   logic              iss_last_q, iss_last_d;

   // Beat rank: aligned with ROM q.
   logic              vld_q, vld_d;
   logic [2:0]        stg_q, stg_d;
   logic [BW-1:0]     but_q, but_d;
   logic              last_q, last_d;
   logic              stage_done_q, stage_done_d;

   logic              active, advance, accept, cnt_last;
   logic [3:0]        shamt;
   logic [BW-1:0]     k_mask, k_val;

   always_comb begin
      active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      advance  = active && (!vld_q || iREADY);
      accept   = vld_q && iREADY;
      cnt_last = (cnt_s_q == LAST_S) && (cnt_b_q == LAST_B);
      // k = (b mod 4^(S-1-s)) * 4^s; the mask shrinks by two bits per stage.
      shamt    = {cnt_s_q, 1'b0};
      k_mask   = LAST_B >> shamt;
      k_val    = (cnt_b_q & k_mask) << shamt;

      state_d      = state_q;
      cnt_s_d      = cnt_s_q;
      cnt_b_d      = cnt_b_q;
      addr_d       = addr_q;
      iss_d        = iss_q;
      iss_s_d      = iss_s_q;
      iss_b_d      = iss_b_q;
      iss_last_d   = iss_last_q;
      vld_d        = vld_q;
      stg_d        = stg_q;
      but_d        = but_q;
      last_d       = last_q;
      stage_done_d = active && accept && last_q;

      case (state_q)
         ST_IDLE:  if (iSTART) state_d = ST_RUN;
         ST_RUN:   if (advance && cnt_last) state_d = ST_DRAIN;
         ST_DRAIN: if (accept && last_q && (stg_q == LAST_S)) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (advance) begin
         vld_d  = iss_q;
         stg_d  = iss_s_q;
         but_d  = iss_b_q;
         last_d = iss_last_q;
         if (state_q == ST_RUN) begin
            iss_d      = 1'b1;
            addr_d     = ADDR_W'(k_val);
            iss_s_d    = cnt_s_q;
            iss_b_d    = cnt_b_q;
            iss_last_d = (cnt_b_q == LAST_B);
            if (cnt_last) begin
               cnt_s_d = '0;
               cnt_b_d = '0;
            end else begin
               cnt_b_d = cnt_b_q + BW'(1);
               if (cnt_b_q == LAST_B) cnt_s_d = cnt_s_q + 3'd1;
            end
         end else begin
            iss_d      = 1'b0;
            iss_s_d    = '0;
            iss_b_d    = '0;
            iss_last_d = 1'b0;
         end
      end

      if (iABORT) begin
         state_d      = ST_IDLE;
         cnt_s_d      = '0;
         cnt_b_d      = '0;
         addr_d       = '0;
         iss_d        = 1'b0;
         iss_s_d      = '0;
         iss_b_d      = '0;
         iss_last_d   = 1'b0;
         vld_d        = 1'b0;
         stg_d        = '0;
         but_d        = '0;
         last_d       = 1'b0;
         stage_done_d = 1'b0;
      end
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_q      <= ST_IDLE;
         cnt_s_q      <= '0;
         cnt_b_q      <= '0;
         addr_q       <= '0;
         iss_q        <= 1'b0;
         iss_s_q      <= '0;
         iss_b_q      <= '0;
         iss_last_q   <= 1'b0;
         vld_q        <= 1'b0;
         stg_q        <= '0;
         but_q        <= '0;
         last_q       <= 1'b0;
         stage_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_s_q      <= cnt_s_d;
         cnt_b_q      <= cnt_b_d;
         addr_q       <= addr_d;
         iss_q        <= iss_d;
         iss_s_q      <= iss_s_d;
         iss_b_q      <= iss_b_d;
         iss_last_q   <= iss_last_d;
         vld_q        <= vld_d;
         stg_q        <= stg_d;
         but_q        <= but_d;
         last_q       <= last_d;
         stage_done_q <= stage_done_d;
      end
   end

   assign oADDR_COEF  = addr_q;
   assign oVALID      = vld_q;
   assign oSTAGE      = stg_q;
   assign oBUT_IDX    = but_q;
   assign oLAST_BUT   = last_q;
   assign oSTAGE_DONE = stage_done_q;
   assign oRDY        = (state_q == ST_DONE);
`ifdef FFT_ROM_GATE_EN
   // ROM captures exactly when both ranks move, so q stays paired with the beat.
   assign oROM_EN     = advance;
`endif

endmodule

// File: tb/tb_fft_twiddle_seq.sv
// Scoreboard bench for fft_twiddle_seq: full runs, latency, stall, random backpressure, abort/restart, ignored start.
module tb_fft_twiddle_seq;
   localparam int S      = 5;
   localparam int NB     = 256;
   localparam int NBEATS = S*NB;
   localparam int AW     = 9;
   localparam int BW     = 2*S-2;

   typedef struct { int s; int b; int k; } beat_t;

   logic          clk, rst_n, start, abort_i, ready;
   logic [AW-1:0] addr;
   logic          vld, last, sdone, rdy, rom_en;
   logic [2:0]    stg;
   logic [BW-1:0] but;
   logic [AW-1:0] rom_q;
   beat_t         exp_q[$];
   int            total = 0;
   int            bad = 0;

   fft_twiddle_seq #(.N_LOG4(S), .ADDR_W(AW)) dut (
      .iCLK(clk), .iRESET(rst_n), .iSTART(start), .iABORT(abort_i), .iREADY(ready),
      .oADDR_COEF(addr), .oVALID(vld), .oSTAGE(stg), .oBUT_IDX(but), .oLAST_BUT(last),
      .oSTAGE_DONE(sdone), .oRDY(rdy)
`ifdef FFT_ROM_GATE_EN
      , .oROM_EN(rom_en)
`endif
   );

`ifndef FFT_ROM_GATE_EN
   // Without the enable port the ROM model captures whenever the beat slot moves.
   assign rom_en = !(vld && !ready);
`endif

   function automatic logic [AW-1:0] rom_f(input int a);
      return AW'((a*7 + 3) % 512);
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) rom_q <= '0;
      else if (rom_en) rom_q <= rom_f(int'(addr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_k(input int s, input int b);
      int q = 1;
      int m = 1;
      for (int i = 0; i < S-1-s; i++) q *= 4;
      for (int i = 0; i < s; i++) m *= 4;
      return (b % q) * m;
   endfunction

   task automatic push_run();
      beat_t e;
      for (int s = 0; s < S; s++)
         for (int b = 0; b < NB; b++) begin
            e.s = s; e.b = b; e.k = model_k(s, b);
            exp_q.push_back(e);
         end
   endtask

   // mode 0: iREADY=1 with stray iSTART pulses; 1: random stalls plus 3-cycle stall at s2,b20; 2: abort at s3,b100
   task automatic run_seq(input int mode);
      int            cyc = 0, n_acc = 0, n_sd = 0, n_rdy = 0, frz = 0;
      bit            done = 0, did_stall = 0;
      beat_t         e;
      logic [AW-1:0] h_addr, h_q;
      logic [2:0]    h_s;
      logic [BW-1:0] h_b;
      push_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      while (!done && cyc < 6000) begin
         if (sdone) n_sd++;
         if (rdy) begin
            n_rdy++;
            done = 1;
            check_eq("rdy_with_stage_done", sdone, 1'b1);
            if (mode == 0) check_eq("rdy_cycle", cyc, NBEATS + 2);
         end
         if (mode == 0 && cyc == 1) check_eq("lat_vld_c1", vld, 1'b0);
         if (mode == 0 && cyc == 2) begin
            check_eq("lat_vld_c2", vld, 1'b1);
            check_eq("lat_stage", stg, 0);
            check_eq("lat_but", but, 0);
            check_eq("lat_q", rom_q, rom_f(0));
         end
         start   = (mode == 0 && (cyc == 100 || cyc == 700));
         abort_i = 1'b0;
         if (frz > 0) begin
            check_eq("stall_addr", addr, h_addr);
            check_eq("stall_vld", vld, 1'b1);
            check_eq("stall_stage", stg, h_s);
            check_eq("stall_but", but, h_b);
            check_eq("stall_q", rom_q, h_q);
            frz--;
            ready = (frz == 0);
         end else if (mode == 1 && !did_stall && vld && stg == 3'd2 && but == BW'(20)) begin
            did_stall = 1;
            frz = 3;
            ready = 1'b0;
            h_addr = addr; h_q = rom_q; h_s = stg; h_b = but;
         end else if (mode == 2 && vld && stg == 3'd3 && but == BW'(100)) begin
            abort_i = 1'b1;
            ready = 1'b1;
         end else begin
            ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         #1;
`ifdef FFT_ROM_GATE_EN
         if (vld && !ready) check_eq("rom_en_stall", rom_en, 1'b0);
`endif
         if (vld && ready && !abort_i) begin
            check_eq("sb_nonempty", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               n_acc++;
               check_eq("beat_stage", stg, e.s);
               check_eq("beat_idx", but, e.b);
               check_eq("beat_last", last, e.b == NB-1);
               check_eq("beat_q", rom_q, rom_f(e.k));
            end
         end
         tick();
         cyc++;
         if (abort_i) begin
            abort_i = 1'b0;
            check_eq("abort_vld", vld, 1'b0);
            check_eq("abort_rdy", rdy, 1'b0);
            check_eq("abort_sdone", sdone, 1'b0);
            repeat (4) begin
               tick();
               check_eq("abort_idle_vld", vld, 1'b0);
               check_eq("abort_idle_rdy", rdy, 1'b0);
`ifdef FFT_ROM_GATE_EN
               check_eq("rom_en_idle", rom_en, 1'b0);
`endif
            end
            exp_q.delete();
            return;
         end
      end
      check_eq("run_finished", done, 1'b1);
      check_eq("beats_accepted", n_acc, NBEATS);
      check_eq("stage_done_pulses", n_sd, S);
      check_eq("rdy_pulses", n_rdy, 1);
      check_eq("sb_left", exp_q.size(), 0);
      exp_q.delete();
      ready = 1'b1;
      repeat (3) begin
         tick();
         check_eq("post_vld", vld, 1'b0);
         check_eq("post_rdy", rdy, 1'b0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b1; abort_i = 1'b0; ready = 1'b1;
      repeat (3) tick();
      check_eq("rst_vld", vld, 1'b0);
      check_eq("rst_addr", addr, 0);
      check_eq("rst_stage", stg, 0);
      check_eq("rst_but", but, 0);
      check_eq("rst_last", last, 1'b0);
      check_eq("rst_sdone", sdone, 1'b0);
      check_eq("rst_rdy", rdy, 1'b0);
`ifdef FFT_ROM_GATE_EN
      check_eq("rst_rom_en", rom_en, 1'b0);
`endif
      rst_n = 1'b1;
      start = 1'b0;
      repeat (3) tick();
      check_eq("start_in_reset_ignored", vld, 1'b0);
      run_seq(0);
      run_seq(1);
      run_seq(2);
      run_seq(0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
